// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI state encoding and default sizing for master and slave
package spi_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int SPI_DATASIZE = 16;
  localparam int SPI_SYNC_STAGES = 2;
  localparam bit CS_ACTIVE_HIGH = 1'b1;
endpackage

// File: rtl/spi_sync_bit.sv
// spi_sync_bit: N-stage single-bit synchroniser with a selectable reset level
module spi_sync_bit
  import spi_pkg::*;
#(
  parameter int   STAGES  = SPI_SYNC_STAGES,
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge CLK) sync_q <= RESET ? {STAGES{RST_VAL}} : sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: mode-0 MSB-first SPI receiver with VALID/READY output and overrun/frame-error pulses
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATASIZE    = SPI_DATASIZE,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES,
  parameter bit CS_ACTIVE   = CS_ACTIVE_HIGH
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SCK,
  input  logic                MOSI,
  input  logic                CS,
  output logic [DATASIZE-1:0] DATA,
  output logic                VALID,
  input  logic                READY,
  output logic                OVERRUN,
  output logic                FRAME_ERR,
  output logic                BUSY
);
  localparam int CW = $clog2(DATASIZE + 1);
  logic s_sck, s_mosi, s_cs, in_shift, wrap;
  logic sck_d_q, sck_d_d, rise_q, rise_d, mosi_q, mosi_d, act_q, act_d;
  logic done_q, done_d, valid_q, valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic [CW-1:0] cnt_q, cnt_d, next_cnt;
  logic [DATASIZE-1:0] shift_q, shift_d, data_q, data_d;
  state_t state_q, state_d;
  spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (.CLK(CLK), .RESET(RESET), .d(SCK), .q(s_sck));
  spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.CLK(CLK), .RESET(RESET), .d(MOSI), .q(s_mosi));
  spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(!CS_ACTIVE)) u_cs (.CLK(CLK), .RESET(RESET), .d(CS), .q(s_cs));
  // rise, MOSI and CS are re-registered together so a CS drop stays aligned with the last rise
  always_comb begin
    in_shift    = state_q == SHIFT;
    sck_d_d     = s_sck;
    rise_d      = s_sck & ~sck_d_q;
    mosi_d      = s_mosi;
    act_d       = s_cs == CS_ACTIVE;
    next_cnt    = cnt_q + CW'(rise_q);
    wrap        = in_shift && rise_q && next_cnt == CW'(DATASIZE);
    state_d     = act_q ? SHIFT : IDLE;
    shift_d     = in_shift && rise_q ? {shift_q[DATASIZE-2:0], mosi_q} : shift_q;
    cnt_d       = in_shift && act_q && !wrap ? next_cnt : '0;
    done_d      = wrap;
    frame_err_d = in_shift && !act_q && !wrap && next_cnt != '0;
    data_d      = done_q && (!valid_q || READY) ? shift_q : data_q;
    valid_d     = done_q || (valid_q && !READY);
    overrun_d   = done_q && valid_q && !READY;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sck_d_q     <= 1'b0;
      rise_q      <= 1'b0;
      mosi_q      <= 1'b0;
      act_q       <= 1'b0;
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sck_d_q     <= sck_d_d;
      rise_q      <= rise_d;
      mosi_q      <= mosi_d;
      act_q       <= act_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end
  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign OVERRUN   = overrun_q;
  assign FRAME_ERR = frame_err_q;
  assign BUSY      = state_q == SHIFT;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: randomized SPI master stimulus checked cycle-by-cycle against a word-level model
module tb_spi_slave_rx;
  logic CLK = 0, RESET = 1, SCK = 0, MOSI = 0, CS = 0, READY = 0;
  logic [15:0] DATA;
  logic VALID, OVERRUN, FRAME_ERR, BUSY;
  always #5 CLK = ~CLK;
  spi_slave_rx #(.DATASIZE(16), .SYNC_STAGES(2), .CS_ACTIVE(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .SCK(SCK), .MOSI(MOSI), .CS(CS), .DATA(DATA), .VALID(VALID),
    .READY(READY), .OVERRUN(OVERRUN), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
  );
  typedef struct {int t; logic [15:0] w;} cmp_t;
  cmp_t pend[$];
  logic [15:0] acc[$];
  int checks = 0, errors = 0, cyc = 0, fe_seen = 0, ovr_seen = 0, rise_cyc = 0;
  int fe_exp = 0, nbits = 0, jit = 0, last_t = 0;
  bit chk_en = 0, rnd_ready = 0, valid_prev = 0;
  logic [15:0] sr = 0, data_m = 0;
  bit valid_m = 0, ovr_m = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Word-level model: a completed word lands SYNC_STAGES+2 edges after its final SCK-high sample
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RESET) begin
      valid_m <= 0; data_m <= 0; ovr_m <= 0;
      pend.delete();
    end else if (pend.size() > 0 && pend[0].t == cyc + 1) begin
      if (!valid_m || READY) begin data_m <= pend[0].w; valid_m <= 1; ovr_m <= 0; end
      else ovr_m <= 1;
      void'(pend.pop_front());
    end else begin
      ovr_m <= 0;
      if (valid_m && READY) valid_m <= 0;
    end
  end
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("valid", VALID, valid_m);
      chk("data", DATA, data_m);
      chk("overrun", OVERRUN, ovr_m);
    end
    if (FRAME_ERR) fe_seen <= fe_seen + 1;
    if (OVERRUN) ovr_seen <= ovr_seen + 1;
    if (VALID && READY) acc.push_back(DATA);
    if (VALID && !valid_prev) rise_cyc <= cyc;
    valid_prev <= VALID;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #(1 + (jit > 0 ? $urandom_range(0, jit) : 0));
    if (rnd_ready) READY = 1'($urandom_range(0, 1));
  endtask
  task automatic send_bit(input logic b, input int pmin, input int pmax, input bit drop);
    MOSI = b;
    tick($urandom_range(pmin, pmax));
    SCK = 1;
    if (drop) CS = 0;
    sr = {sr[14:0], b};
    nbits++;
    last_t = cyc + 1;
    if (nbits == 16) begin pend.push_back('{cyc + 5, sr}); nbits = 0; end
    tick($urandom_range(pmin, pmax));
    SCK = 0;
  endtask
  task automatic send_word(input logic [15:0] w, input int pmin, input int pmax, input bit drop);
    for (int i = 15; i >= 0; i--) send_bit(w[i], pmin, pmax, drop && i == 0);
  endtask
  task automatic cs_on();
    CS = 1;
    tick(2);
  endtask
  task automatic cs_off();
    if (nbits != 0) fe_exp++;
    nbits = 0;
    CS = 0;
    tick(4);
  endtask
  initial begin
    int ovr0;
    logic [15:0] w;
    tick(3);
    RESET = 0;
    tick(1);
    chk("reset_data", DATA, 0);
    chk("reset_valid", VALID, 0);
    chk("reset_overrun", OVERRUN, 0);
    chk("reset_frame_err", FRAME_ERR, 0);
    chk("reset_busy", BUSY, 0);
    chk_en = 1;
    READY = 1;
    cs_on();
    send_word(16'hA5C3, 1, 1, 0);
    chk("busy_in_frame", BUSY, 1);
    send_word(16'h0001, 1, 1, 0);
    cs_off();
    tick(6);
    chk("loop_count", acc.size(), 2);
    if (acc.size() == 2) begin
      chk("loop_word0", acc[0], 16'hA5C3);
      chk("loop_word1", acc[1], 16'h0001);
    end
    chk("loop_overrun", ovr_seen, 0);
    chk("loop_frame_err", fe_seen, 0);
    chk("idle_busy", BUSY, 0);
    READY = 0;
    ovr0 = ovr_seen;
    cs_on();
    send_word(16'h1234, 1, 2, 0);
    send_word(16'hBEEF, 1, 2, 0);
    cs_off();
    tick(6);
    chk("bp_data", DATA, 16'h1234);
    chk("bp_valid", VALID, 1);
    chk("bp_overruns", ovr_seen - ovr0, 1);
    READY = 1;
    tick(1);
    chk("bp_release", VALID, 0);
    cs_on();
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)), 1, 2, 0);
    cs_off();
    tick(6);
    chk("abort_frame_err", fe_seen, 1);
    chk("abort_valid", VALID, 0);
    cs_on();
    send_word(16'h00FF, 1, 1, 0);
    cs_off();
    tick(6);
    chk("abort_next_word", DATA, 16'h00FF);
    jit = 7;
    cs_on();
    send_word(16'h8001, 4, 6, 0);
    cs_off();
    jit = 0;
    tick(6);
    chk("slow_data", DATA, 16'h8001);
    chk("slow_latency", rise_cyc - last_t, 4);
    READY = 0;
    cs_on();
    send_word(16'h1111, 1, 1, 0);
    send_word(16'h2222, 1, 1, 1);
    SCK = 0;
    for (int k = 0; k < 20 && cyc < last_t + 3; k++) tick(1);
    READY = 1;
    tick(1);
    chk("simul_valid", VALID, 1);
    chk("simul_data", DATA, 16'h2222);
    chk("simul_overrun", OVERRUN, 0);
    tick(6);
    chk("simul_frame_err", fe_seen, fe_exp);
    cs_on();
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1, 1, 0);
    RESET = 1;
    tick(1);
    RESET = 0;
    nbits = 0;
    chk("rst_data", DATA, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_frame_err", FRAME_ERR, 0);
    chk("rst_busy", BUSY, 0);
    tick(4);
    send_word(16'hFFFF, 1, 2, 0);
    cs_off();
    tick(6);
    chk("rst_next_word", DATA, 16'hFFFF);
    chk("rst_no_frame_err", fe_seen, fe_exp);
    rnd_ready = 1;
    for (int f = 0; f < 8; f++) begin
      jit = $urandom_range(0, 8);
      cs_on();
      for (int k = $urandom_range(1, 3); k > 0; k--) begin
        w = 16'($urandom);
        send_word(w, 1, 3, 0);
      end
      if ($urandom_range(0, 1) == 1)
        for (int p = $urandom_range(1, 15); p > 0; p--) send_bit(1'($urandom_range(0, 1)), 1, 3, 0);
      cs_off();
    end
    rnd_ready = 0;
    jit = 0;
    READY = 1;
    tick(10);
    chk("final_frame_err", fe_seen, fe_exp);
    chk("final_valid_drained", VALID, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
